// File: rtl/pila_retorno_if.sv
// Bundle between the control unit/datapath and the return-address stack.
// The control unit side is the master; the stack itself is the slave.
interface pila_retorno_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
);
    logic                     push;
    logic                     pop;
    logic                     clr_err;
    logic [WIDTH-1:0]         din;
    logic [WIDTH-1:0]         dout;
    logic [$clog2(DEPTH):0]   count;
    logic                     empty;
    logic                     full;
    logic                     ovf;
    logic                     unf;

    modport master (
        output push, pop, clr_err, din,
        input  dout, count, empty, full, ovf, unf
    );

    modport slave (
        input  push, pop, clr_err, din,
        output dout, count, empty, full, ovf, unf
    );
endinterface

// File: rtl/pila_retorno.sv
// Return-address stack for call/return: non-wrapping, depth-tracked, with
// sticky overflow/underflow flags and a zero-latency top-of-stack read.
module pila_retorno #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset,
    pila_retorno_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    sp;
    logic             ovf_q;
    logic             unf_q;

    logic             is_empty;
    logic             is_full;
    logic [PW-1:0]    top_idx;
    logic             wr_en;
    logic [PW-1:0]    wr_addr;
    logic [CW-1:0]    sp_next;
    logic             ovf_set;
    logic             unf_set;

    assign is_empty = (sp == '0);
    assign is_full  = (sp == CW'(DEPTH));
    // At sp==DEPTH the low bits are zero, so the subtraction wraps to DEPTH-1.
    assign top_idx  = sp[PW-1:0] - PW'(1);

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = sp[PW-1:0];
        sp_next = sp;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case ({bus.push, bus.pop})
            2'b10: begin
                if (is_full) begin
                    ovf_set = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    sp_next = sp + CW'(1);
                end
            end
            2'b01: begin
                if (is_empty) begin
                    unf_set = 1'b1;
                end else begin
                    sp_next = sp - CW'(1);
                end
            end
            2'b11: begin
                wr_en = 1'b1;
                if (is_empty) begin
                    // Unmatched return paired with a call: keep the call, flag the return.
                    wr_addr = '0;
                    sp_next = CW'(1);
                    unf_set = 1'b1;
                end else begin
                    wr_addr = top_idx;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp    <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            sp    <= sp_next;
            ovf_q <= ovf_set | (ovf_q & ~bus.clr_err);
            unf_q <= unf_set | (unf_q & ~bus.clr_err);
        end
    end

    // Storage is never cleared; an empty stack reads as zero instead.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wr_addr] <= bus.din;
        end
    end

    assign bus.dout  = is_empty ? '0 : mem[top_idx];
    assign bus.count = sp;
    assign bus.empty = is_empty;
    assign bus.full  = is_full;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;
endmodule

// File: tb/tb_pila_retorno.sv
// Bench for pila_retorno: directed scenarios followed by random traffic,
// all compared against a queue-based model of the stack.
module tb_pila_retorno;
    localparam int W = 10;
    localparam int D = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    pila_retorno_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pila_retorno #(.WIDTH(W), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    logic         m_ovf = 1'b0;
    logic         m_unf = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input logic p, input logic po, input logic [W-1:0] d,
                               input logic c, input logic r);
        logic o;
        logic u;
        o = 1'b0;
        u = 1'b0;
        if (r) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && !po) begin
                if (q.size() < D) q.push_back(d);
                else o = 1'b1;
            end else if (!p && po) begin
                if (q.size() > 0) void'(q.pop_back());
                else u = 1'b1;
            end else if (p && po) begin
                if (q.size() > 0) q[q.size()-1] = d;
                else begin
                    q.push_back(d);
                    u = 1'b1;
                end
            end
            m_ovf = o | (m_ovf & ~c);
            m_unf = u | (m_unf & ~c);
        end
    endtask

    // Drive one cycle of request, clock it, update the model, compare all outputs.
    task automatic cycle(input logic p, input logic po, input logic [W-1:0] d,
                         input logic c, input logic r);
        logic [W-1:0] exp_dout;
        bus.push    = p;
        bus.pop     = po;
        bus.din     = d;
        bus.clr_err = c;
        reset       = r;
        @(posedge clk);
        #1;
        model_apply(p, po, d, c, r);
        exp_dout = (q.size() > 0) ? q[q.size()-1] : '0;
        chk("dout",  32'(bus.dout),  32'(exp_dout));
        chk("count", 32'(bus.count), 32'(q.size()));
        chk("full",  32'(bus.full),  32'(q.size() == D));
        chk("empty", 32'(bus.empty), 32'(q.size() == 0));
        chk("ovf",   32'(bus.ovf),   32'(m_ovf));
        chk("unf",   32'(bus.unf),   32'(m_unf));
    endtask

    initial begin
        int pth;
        int qth;
        int rr;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.clr_err = 1'b0; reset = 1'b1;

        cycle(0, 0, '0, 0, 1);
        cycle(0, 0, '0, 0, 1);
        chk("rst_dout",  32'(bus.dout),  32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_flags", 32'({bus.full, bus.ovf, bus.unf}), 32'h0);

        cycle(1, 0, 10'h011, 0, 0);
        cycle(1, 0, 10'h022, 0, 0);
        cycle(1, 0, 10'h033, 0, 0);
        chk("lifo_top", 32'(bus.dout), 32'h033);
        chk("lifo_cnt", 32'(bus.count), 32'd3);
        cycle(0, 1, '0, 0, 0);
        chk("lifo_pop1", 32'(bus.dout), 32'h022);
        cycle(0, 1, '0, 0, 0);
        chk("lifo_pop2", 32'(bus.dout), 32'h011);
        cycle(0, 1, '0, 0, 0);
        chk("lifo_pop3", 32'(bus.dout), 32'h0);
        chk("lifo_empty", 32'(bus.empty), 32'h1);
        chk("lifo_flags", 32'({bus.ovf, bus.unf}), 32'h0);

        for (int i = 0; i < D; i++) cycle(1, 0, W'(10'h100 + i), 0, 0);
        cycle(1, 0, 10'h3FF, 0, 0);
        chk("ovf_full",  32'(bus.full),  32'h1);
        chk("ovf_count", 32'(bus.count), 32'(D));
        chk("ovf_dout",  32'(bus.dout),  32'(10'h100 + D - 1));
        chk("ovf_flag",  32'(bus.ovf),   32'h1);
        cycle(0, 0, '0, 0, 1);

        cycle(0, 1, '0, 0, 0);
        chk("unf_flag",  32'(bus.unf),   32'h1);
        chk("unf_count", 32'(bus.count), 32'h0);
        chk("unf_dout",  32'(bus.dout),  32'h0);
        cycle(0, 0, '0, 1, 0);
        chk("unf_clr", 32'(bus.unf), 32'h0);
        cycle(0, 1, '0, 1, 0);
        chk("unf_setwins", 32'(bus.unf), 32'h1);
        cycle(0, 0, '0, 1, 0);

        cycle(1, 0, 10'h055, 0, 0);
        cycle(1, 1, 10'h0AA, 0, 0);
        chk("repl_count", 32'(bus.count), 32'd1);
        chk("repl_dout",  32'(bus.dout),  32'h0AA);
        cycle(0, 1, '0, 0, 0);
        cycle(1, 1, 10'h123, 0, 0);
        chk("repl_e_count", 32'(bus.count), 32'd1);
        chk("repl_e_dout",  32'(bus.dout),  32'h123);
        chk("repl_e_unf",   32'(bus.unf),   32'h1);

        for (int i = 0; i < 5; i++) cycle(1, 0, W'(i + 1), 0, 0);
        cycle(1, 0, 10'h2AA, 0, 1);
        chk("rstp_count", 32'(bus.count), 32'h0);
        chk("rstp_empty", 32'(bus.empty), 32'h1);
        chk("rstp_dout",  32'(bus.dout),  32'h0);
        chk("rstp_flags", 32'({bus.ovf, bus.unf}), 32'h0);
        cycle(1, 0, 10'h007, 0, 0);
        chk("rstp_push_dout",  32'(bus.dout),  32'h007);
        chk("rstp_push_count", 32'(bus.count), 32'd1);

        // Alternate push-heavy and pop-heavy phases so both full and empty are reached.
        for (int i = 0; i < 10000; i++) begin
            pth = ((i / 500) % 2 == 0) ? 70 : 30;
            qth = ((i / 500) % 2 == 0) ? 30 : 70;
            rr  = $urandom_range(0, 999);
            cycle(logic'($urandom_range(0, 99) < pth),
                  logic'($urandom_range(0, 99) < qth),
                  W'($urandom_range(0, 1023)),
                  logic'($urandom_range(0, 99) < 5),
                  logic'(rr < 2));
        end

        bus.push = 1'b0; bus.pop = 1'b0; bus.clr_err = 1'b0; reset = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pila_retorno.md
# pila_retorno

Return-address stack serving the control unit's `push`/`pop` call/return instructions. On a call, the datapath presents the return address (PC+1) on `din` while the control unit asserts `push`. On a return, the control unit asserts `pop` with `s_pila=1`, and the PC mux takes `dout` in the same cycle. The block adds depth tracking, full/empty status and sticky overflow/underflow error flags, so runaway recursion or unmatched returns are detectable by software through the I/O ports.

## Interface
Parameters:
- `WIDTH`, 10, stored address width (matches the 10-bit jump-target field).
- `DEPTH`, 16, number of entries; must be a power of 2, at least 2.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `push`  in  1  write `din` as the new top of stack.
- `pop`  in  1  discard the top of stack.
- `din`  in  WIDTH  return address to store.
- `clr_err`  in  1  clear the sticky `ovf`/`unf` flags.
- `dout`  out  WIDTH  current top of stack, combinational from the pointer and storage.
- `count`  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- `empty`  out  1  high when `count==0`.
- `full`  out  1  high when `count==DEPTH`.
- `ovf`  out  1  sticky: a push was attempted while full.
- `unf`  out  1  sticky: a pop was attempted while empty.

## Operation
- State: storage array `mem[0..DEPTH-1]`, pointer `sp` (equal to `count`), `ovf` and `unf` registers.
- Top of stack: `dout = mem[sp-1]` when `sp>0`; `dout = 0` when empty.
- The stack does not wrap around; `sp` saturates at 0 and at DEPTH.
- Per-cycle action on `{push,pop}`:
  - 00: hold.
  - 10, not full: `mem[sp] <= din`, `sp <= sp+1`.
  - 10, full: no write, `sp` unchanged, `ovf <= 1`.
  - 01, not empty: `sp <= sp-1`; storage untouched.
  - 01, empty: `sp` stays 0, `unf <= 1`.
  - 11, not empty: replace top. `mem[sp-1] <= din`, `sp` unchanged. The full state does not matter here, and no `ovf` is raised.
  - 11, empty: push executes (`mem[0] <= din`, `sp <= 1`) and `unf <= 1`.
- `clr_err`: clears `ovf` and `unf`. If a new overflow/underflow happens in the same cycle, the set wins and the corresponding flag stays 1.
- `reset`: `sp <= 0`, `ovf <= 0`, `unf <= 0`. Storage contents are not cleared; they are unobservable because `dout` reads 0 while empty. Reset has priority over push, pop and `clr_err` in the same cycle.

## Timing
- Reset values: `dout=0`, `count=0`, `empty=1`, `full=0`, `ovf=0`, `unf=0`.
- Read latency is 0: `dout` reflects the current top during the cycle a `pop` is asserted. The control unit's PC load in that cycle captures the pre-pop top.
- Push: at the edge ending cycle N, `din` is stored. `dout==din` and `count` has incremented from cycle N+1.
- Pop: `count` decrements and `dout` shows the next-lower entry from cycle N+1.
- Replace (11, not empty): `dout` shows the old top in cycle N and the new `din` from N+1.
- `empty`, `full` and `count` are derived from registered `sp`. They change only after a clock edge.
- `ovf`/`unf` are visible in the cycle after the offending request.
- No handshake or back-pressure: every request is consumed in one cycle. Illegal requests are dropped and flagged.

## Test plan
- Reset, then push 0x011, 0x022, 0x033 on consecutive cycles, then pop ×3. Required: `dout` sequence 0x033, 0x022, 0x011, then 0; `count` 3→0; `empty` high at the end; no error flags.
- Push DEPTH values 0x100+i, then one more push of 0x3FF. Required: `full=1`, `count=DEPTH`, `dout=0x100+DEPTH-1` (0x3FF not stored), `ovf=1` next cycle.
- With the stack empty, pop. Required: `unf=1`, `count=0`, `dout=0`. Then pulse `clr_err`. Required: `unf=0`. Then pop again with `clr_err` held high. Required: `unf=1`.
- Push 0x055, then push+pop with `din=0x0AA`. Required: `count` stays 1, `dout=0x0AA`. Then push+pop on empty with `din=0x123`. Required: `count=1`, `dout=0x123`, `unf=1`.
- Push 5 entries, then assert `reset` together with `push`. Required next cycle: `count=0`, `empty=1`, `dout=0`, flags 0. Then push 0x007. Required: `dout=0x007`, `count=1`.
- Randomised push/pop/`clr_err` for 10k cycles against a queue reference model. Required: `dout`, `count`, `full`, `empty`, `ovf` and `unf` match every cycle.
